lp_control_unit_v2: RTL
=======================

LP_CONTROL_UNIT_V2 -- requirements
Module: lp_control_unit_v2

Interface
REQ-001 Parameter OPW, default 4: opcode width, legal range 4 to 8.
REQ-002 Parameter IDLE_LIMIT, default 8: consecutive non-accept cycles before sleep; 0 disables sleep.
REQ-003 Parameter CNTW, default 16: width of the statistics counters.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high. Ports: clk, rst.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  OPW  instruction opcode
- valid  in  1  opcode is valid
- ready  out  1  block accepts an opcode this cycle
- mem_done  in  1  memory op complete
- out_valid  out  1  one-cycle pulse: control outputs updated
- reg_write, mem_read, mem_write, alu_src, branch, jump  out  1 each  control strobes
- alu_op  out  3  ALU operation
- illegal  out  1  one-cycle pulse: undefined opcode accepted
- sleep  out  1  block is in SLEEP
- instr_cnt  out  CNTW  accepted-opcode count (only with the REQ-019 macro)
- illegal_cnt  out  CNTW  illegal-opcode count (only with the REQ-019 macro)

Function
REQ-006 Accept SHALL occur when valid && ready; ready = (state == ACTIVE).
REQ-007 On accept, all control outputs SHALL be registered with 1-cycle latency, and out_valid SHALL pulse for one cycle.
REQ-008 Without an accept, control outputs SHALL hold their previous values (no toggling), and out_valid SHALL be 0.
REQ-009 Decode SHALL be, with each entry giving reg_write/mem_read/mem_write/alu_src/branch/jump then alu_op:
- 0 NOP: 000000, 000
- 1 ADD: 100000, 000
- 2 SUB: 100000, 001
- 3 AND: 100000, 010
- 4 OR: 100000, 011
- 5 XOR: 100000, 100
- 6 LOAD: 110100, 000
- 7 STORE: 001100, 000
- 8 BRANCH: 000010, 001
- 9 JUMP: 000001, 000
- A SLL: 100000, 101
- B SRL: 100000, 110
REQ-010 Opcode values 0xC and above (including any nonzero bit above bit 3) SHALL be illegal: decode as NOP and pulse illegal together with out_valid.
REQ-011 FSM states SHALL be ACTIVE, MEM_WAIT and SLEEP.
REQ-012 ACTIVE transitions:
- Accepted LOAD or STORE -> MEM_WAIT.
- Idle counter reaching IDLE_LIMIT (IDLE_LIMIT > 0) -> SLEEP.
- Otherwise stay in ACTIVE.
REQ-013 MEM_WAIT behaviour:
- ready = 0.
- mem_done is sampled only in MEM_WAIT; mem_done = 1 -> ACTIVE, with ready = 1 on the following cycle.
- mem_done asserted on the accept cycle itself SHALL be ignored.
REQ-014 SLEEP behaviour:
- sleep = 1 and ready = 0.
- valid = 1 -> ACTIVE next cycle.
- The opcode is not consumed during SLEEP; the requester holds valid and opcode.
REQ-015 Idle counter behaviour:
- Increments each ACTIVE cycle without an accept.
- Clears on accept and on entry to ACTIVE.
- Saturates at IDLE_LIMIT.
- Does not count in MEM_WAIT.
REQ-016 valid dropping while in MEM_WAIT SHALL have no effect; opcode is don't-care when valid = 0.

Reset
REQ-017 While rst = 1:
- state -> ACTIVE, idle counter -> 0.
- All control outputs, alu_op, out_valid, illegal and sleep -> 0.
- Counters -> 0.
- ready = 1 from the first cycle after rst deasserts.
REQ-018 rst asserted in MEM_WAIT or SLEEP SHALL abandon the operation, with no out_valid pulse.

Configuration
REQ-019 Macro LP_CONTROL_UNIT_STATS_EN:
- Defined: instr_cnt increments on every accept, and illegal_cnt increments on every illegal accept; both wrap modulo 2^CNTW.
- Undefined: both ports are absent and no counter logic is built.

Verification
REQ-020 After reset, feed opcodes 0x0 to 0xB back-to-back with valid = 1 -> each produces the REQ-009 pattern one cycle later with out_valid = 1; LOAD and STORE each stall ready until mem_done.
REQ-021 Accept LOAD, hold mem_done = 0 for 5 cycles, then 1 -> ready = 0 for 6 cycles, mem_read = 1 is held throughout, and ready = 1 on the cycle after mem_done.
REQ-022 With IDLE_LIMIT = 8, valid = 0 for 8 cycles -> sleep = 1 on cycle 9 and outputs unchanged; then valid = 1 with ADD -> ready = 1 the next cycle and ADD is accepted.
REQ-023 OPW = 6, opcode 0x11 -> illegal = 1, all strobes 0, alu_op = 000, illegal_cnt = 1 when the macro is defined.
REQ-024 Assert rst during MEM_WAIT -> next cycle state ACTIVE, all outputs 0, sleep = 0, ready = 1 after rst deasserts.

Source files
------------

// File: rtl/lp_control_unit_v2.sv
// Low-power instruction control unit: registered opcode decode, memory-wait stall and idle sleep.
// Optional statistics counters are built when LP_CONTROL_UNIT_STATS_EN is defined.
module lp_control_unit_v2 #(
    parameter int OPW        = 4,
    parameter int IDLE_LIMIT = 8,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            valid,
    output logic            ready,
    input  logic            mem_done,
    output logic            out_valid,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      alu_op,
    output logic            illegal,
    output logic            sleep
`ifdef LP_CONTROL_UNIT_STATS_EN
    ,
    output logic [CNTW-1:0] instr_cnt,
    output logic [CNTW-1:0] illegal_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_SLEEP    = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam int IDW = (IDLE_LIMIT < 1) ? 1 : $clog2(IDLE_LIMIT + 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] idle_cnt_q, idle_cnt_d;
    ctrl_t          ctrl_q, ctrl_d, dec_ctrl;
    logic           out_valid_q, out_valid_d;
    logic           illegal_q, illegal_d;
    logic           accept, dec_illegal, dec_is_mem, idle_hit;

    assign accept = valid && ready;

    // Any set bit above bit 3 makes the opcode illegal regardless of the low nibble.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        if ((opcode >> 4) != '0) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                4'h0:    dec_ctrl = ctrl_t'(9'b000000_000);
                4'h1:    dec_ctrl = ctrl_t'(9'b100000_000);
                4'h2:    dec_ctrl = ctrl_t'(9'b100000_001);
                4'h3:    dec_ctrl = ctrl_t'(9'b100000_010);
                4'h4:    dec_ctrl = ctrl_t'(9'b100000_011);
                4'h5:    dec_ctrl = ctrl_t'(9'b100000_100);
                4'h6:    dec_ctrl = ctrl_t'(9'b110100_000);
                4'h7:    dec_ctrl = ctrl_t'(9'b001100_000);
                4'h8:    dec_ctrl = ctrl_t'(9'b000010_001);
                4'h9:    dec_ctrl = ctrl_t'(9'b000001_000);
                4'hA:    dec_ctrl = ctrl_t'(9'b100000_101);
                4'hB:    dec_ctrl = ctrl_t'(9'b100000_110);
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign dec_is_mem = dec_ctrl.mem_read || dec_ctrl.mem_write;
    assign idle_hit   = (IDLE_LIMIT != 0) && (idle_cnt_q == IDW'(IDLE_LIMIT - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (accept && dec_is_mem) begin
                    state_d = ST_MEM_WAIT;
                end else if (!accept && idle_hit) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_MEM_WAIT: if (mem_done) state_d = ST_ACTIVE;
            ST_SLEEP:    if (valid)    state_d = ST_ACTIVE;
            default:     state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_ACTIVE);
        sleep = (state_q == ST_SLEEP);
    end

    // Idle count clears on accept and whenever the FSM re-enters ACTIVE, and saturates at the limit.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (accept || (state_q != ST_ACTIVE && state_d == ST_ACTIVE)) begin
            idle_cnt_d = '0;
        end else if (state_q == ST_ACTIVE && IDLE_LIMIT != 0 && idle_cnt_q != IDW'(IDLE_LIMIT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ctrl_d      = accept ? dec_ctrl : ctrl_q;
        out_valid_d = accept;
        illegal_d   = accept && dec_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q  <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign reg_write = ctrl_q.reg_write;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign alu_src   = ctrl_q.alu_src;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;
    assign alu_op    = ctrl_q.alu_op;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;

`ifdef LP_CONTROL_UNIT_STATS_EN
    logic [CNTW-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNTW-1:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        instr_cnt_d   = instr_cnt_q + CNTW'(accept);
        illegal_cnt_d = illegal_cnt_q + CNTW'(accept && dec_illegal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            instr_cnt_q   <= instr_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign instr_cnt   = instr_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
